// File: rtl/riscv_core_pkg.sv
// Shared core package: M-extension encodings and sequencer state
// for the execute-stage multiply/divide controller.
package riscv_core_pkg;

    localparam int MULDIV_MAX_WAIT = 64;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_MUL_WAIT,
        MD_DIV_WAIT,
        MD_RESP,
        MD_DRAIN
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_special_case.sv
// RISC-V divide corner cases that never need the divider:
// divide by zero and signed overflow (MIN_INT / -1).
module muldiv_special_case
    import riscv_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            is_special_o,
    output logic [XLEN-1:0] special_result_o
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_op_e op;
    logic       is_div;
    logic       is_rem;
    logic       is_signed;
    logic       div_zero;
    logic       overflow;

    always_comb begin
        op               = muldiv_op_e'(funct3_i);
        is_div           = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        is_rem           = op inside {OP_REM, OP_REMU};
        is_signed        = op inside {OP_DIV, OP_REM};
        div_zero         = (op_b_i == '0);
        overflow         = is_signed && (op_a_i == MIN_INT) && (op_b_i == '1);
        is_special_o     = is_div && (div_zero || overflow);
        special_result_o = '0;
        if (div_zero) begin
            special_result_o = is_rem ? op_a_i : '1;
        end else if (overflow) begin
            special_result_o = is_rem ? '0 : MIN_INT;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between execute and the multi-cycle mult/div units:
// launch, watchdog, registered response, flush and drain.
module muldiv_ctrl
    import riscv_core_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = MULDIV_MAX_WAIT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_op_a_i,
    input  logic [XLEN-1:0] req_op_b_i,
    input  logic [4:0]      req_rd_i,
    input  logic            flush_i,
    output logic            mult_start_o,
    output logic            div_start_o,
    output logic [XLEN-1:0] unit_op_a_o,
    output logic [XLEN-1:0] unit_op_b_o,
    output logic [2:0]      unit_funct3_o,
    input  logic            mult_done_i,
    input  logic            div_done_i,
    input  logic [XLEN-1:0] mult_result_i,
    input  logic [XLEN-1:0] div_result_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_result_o,
    output logic [4:0]      resp_rd_o,
    output logic            resp_err_o,
    output logic            busy_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    muldiv_state_e   state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            err_q, err_d;
    logic            resp_valid_q, resp_valid_d;
    logic            mult_start_q, mult_start_d;
    logic            div_start_q, div_start_d;

    logic            is_special;
    logic [XLEN-1:0] special_result;
    logic            accept;
    logic            awaited_done;
    logic [XLEN-1:0] awaited_result;
    logic            timeout;

    muldiv_special_case #(
        .XLEN(XLEN)
    ) u_special (
        .funct3_i        (req_funct3_i),
        .op_a_i          (req_op_a_i),
        .op_b_i          (req_op_b_i),
        .is_special_o    (is_special),
        .special_result_o(special_result)
    );

    assign req_ready_o = (state_q == MD_IDLE) && !flush_i && !rst_i;
    assign busy_o      = (state_q != MD_IDLE);
    assign accept      = req_valid_i && req_ready_o;

    // The captured funct3 selects the awaited unit in both WAIT and DRAIN.
    assign awaited_done   = funct3_q[2] ? div_done_i : mult_done_i;
    assign awaited_result = funct3_q[2] ? div_result_i : mult_result_i;
    assign timeout        = (cnt_q == CW'(MAX_WAIT));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        result_d     = result_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        mult_start_d = 1'b0;
        div_start_d  = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    op_a_d   = req_op_a_i;
                    op_b_d   = req_op_b_i;
                    funct3_d = req_funct3_i;
                    rd_d     = req_rd_i;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    if (!req_funct3_i[2]) begin
                        mult_start_d = 1'b1;
                        state_d      = MD_MUL_WAIT;
                    end else if (is_special) begin
                        result_d     = special_result;
                        resp_valid_d = 1'b1;
                        state_d      = MD_RESP;
                    end else begin
                        div_start_d = 1'b1;
                        state_d     = MD_DIV_WAIT;
                    end
                end
            end
            MD_MUL_WAIT, MD_DIV_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (flush_i) begin
                    cnt_d   = '0;
                    state_d = awaited_done ? MD_IDLE : MD_DRAIN;
                end else if (awaited_done) begin
                    result_d     = awaited_result;
                    err_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = MD_RESP;
                end else if (timeout) begin
                    result_d     = '0;
                    err_d        = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = MD_RESP;
                end
            end
            MD_RESP: begin
                if (flush_i || resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    err_d        = 1'b0;
                    state_d      = MD_IDLE;
                end
            end
            MD_DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (awaited_done || timeout) begin
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= MD_IDLE;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            funct3_q     <= '0;
            rd_q         <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            result_q     <= result_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
        end
    end

    assign mult_start_o  = mult_start_q;
    assign div_start_o   = div_start_q;
    assign unit_op_a_o   = op_a_q;
    assign unit_op_b_o   = op_b_q;
    assign unit_funct3_o = funct3_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_result_o = result_q;
    assign resp_rd_o     = rd_q;
    assign resp_err_o    = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed requests push expected
// responses, a negedge monitor pops them on each response handshake.
module tb_muldiv_ctrl;

    localparam int XLEN = 32;
    localparam int MW   = 16;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_op_a;
    logic [31:0] req_op_b;
    logic [4:0]  req_rd;
    logic        flush;
    logic        mult_start;
    logic        div_start;
    logic [31:0] unit_op_a;
    logic [31:0] unit_op_b;
    logic [2:0]  unit_funct3;
    logic        mult_done;
    logic        div_done;
    logic [31:0] mult_result;
    logic [31:0] div_result;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        busy;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    muldiv_ctrl #(
        .XLEN    (XLEN),
        .MAX_WAIT(MW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_funct3_i (req_funct3),
        .req_op_a_i   (req_op_a),
        .req_op_b_i   (req_op_b),
        .req_rd_i     (req_rd),
        .flush_i      (flush),
        .mult_start_o (mult_start),
        .div_start_o  (div_start),
        .unit_op_a_o  (unit_op_a),
        .unit_op_b_o  (unit_op_b),
        .unit_funct3_o(unit_funct3),
        .mult_done_i  (mult_done),
        .div_done_i   (div_done),
        .mult_result_i(mult_result),
        .div_result_i (div_result),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_result_o(resp_result),
        .resp_rd_o    (resp_rd),
        .resp_err_o   (resp_err),
        .busy_o       (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every response handshake must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got %h rd %0d, none expected", resp_result, resp_rd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_result", resp_result, e.res);
                chk("resp_rd", 32'(resp_rd), 32'(e.rd));
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    // Present a request from just after a posedge; returns in cycle N+1.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        int n = 0;
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_op_a   = a;
        req_op_b   = b;
        req_rd     = rd;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_op_a   = 32'hA5A5_A5A5;
        req_op_b   = 32'h5A5A_5A5A;
        req_funct3 = 3'b010;
        req_rd     = 5'd31;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int early;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_funct3  = '0;
        req_op_a    = '0;
        req_op_b    = '0;
        req_rd      = '0;
        flush       = 1'b0;
        mult_done   = 1'b0;
        div_done    = 1'b0;
        mult_result = 32'hBAD0_0001;
        div_result  = 32'hBAD0_0002;
        resp_ready  = 1'b1;

        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(resp_valid), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 1);

        // MUL 7x6, done three cycles after start
        step();
        sb.push_back('{res: 32'd42, rd: 5'd5, err: 1'b0});
        issue(3'b000, 32'd7, 32'd6, 5'd5);
        @(negedge clk);
        chk("mul_start", 32'(mult_start), 1);
        chk("mul_div_start", 32'(div_start), 0);
        chk("mul_busy", 32'(busy), 1);
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 3) begin
                mult_done   = 1'b1;
                mult_result = 32'd42;
            end
            @(negedge clk);
            chk("mul_wait_busy", 32'(busy), 1);
            chk("mul_wait_nodiv", 32'(div_start), 0);
            chk("mul_wait_novalid", 32'(resp_valid), 0);
        end
        chk("mul_op_a_held", unit_op_a, 32'd7);
        chk("mul_op_b_held", unit_op_b, 32'd6);
        step();
        mult_done   = 1'b0;
        mult_result = 32'hBAD0_0001;
        @(negedge clk);
        chk("mul_latency", 32'(resp_valid), 1);
        chk("mul_resp_busy", 32'(busy), 1);
        step();
        @(negedge clk);
        chk("mul_back_idle", 32'(busy), 0);

        // Divide special cases, latency 1, no unit launch
        step();
        sb.push_back('{res: 32'hFFFF_FFFF, rd: 5'd1, err: 1'b0});
        issue(3'b101, 32'd100, 32'd0, 5'd1);
        @(negedge clk);
        chk("divu0_valid", 32'(resp_valid), 1);
        chk("divu0_nostart", 32'(div_start), 0);
        step();
        sb.push_back('{res: 32'd100, rd: 5'd2, err: 1'b0});
        issue(3'b111, 32'd100, 32'd0, 5'd2);
        @(negedge clk);
        chk("remu0_valid", 32'(resp_valid), 1);
        chk("remu0_nostart", 32'(div_start), 0);
        step();
        sb.push_back('{res: 32'h8000_0000, rd: 5'd3, err: 1'b0});
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
        @(negedge clk);
        chk("divovf_valid", 32'(resp_valid), 1);
        chk("divovf_nostart", 32'(div_start), 0);
        step();
        sb.push_back('{res: 32'd0, rd: 5'd4, err: 1'b0});
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        @(negedge clk);
        chk("removf_valid", 32'(resp_valid), 1);
        chk("removf_nostart", 32'(div_start), 0);
        step();

        // Normal DIV 20/3 with a stray mult_done to ignore
        sb.push_back('{res: 32'd6, rd: 5'd6, err: 1'b0});
        issue(3'b100, 32'd20, 32'd3, 5'd6);
        mult_done = 1'b1;
        @(negedge clk);
        chk("div_start", 32'(div_start), 1);
        chk("div_mul_start", 32'(mult_start), 0);
        step();
        mult_done  = 1'b0;
        div_done   = 1'b1;
        div_result = 32'd6;
        @(negedge clk);
        chk("div_stray_ignored", 32'(resp_valid), 0);
        step();
        div_done   = 1'b0;
        div_result = 32'hBAD0_0002;
        @(negedge clk);
        chk("div_latency", 32'(resp_valid), 1);
        step();

        // DIV with flush two cycles after start, drained done later
        issue(3'b100, 32'd20, 32'd3, 5'd7);
        step();
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready_low", 32'(req_ready), 0);
        for (int k = 3; k <= 6; k++) begin
            step();
            flush = 1'b0;
            if (k == 6) begin
                div_done   = 1'b1;
                div_result = 32'd6;
            end
            @(negedge clk);
            chk("drain_ready_low", 32'(req_ready), 0);
            chk("drain_busy", 32'(busy), 1);
        end
        step();
        div_done   = 1'b0;
        div_result = 32'hBAD0_0002;
        @(negedge clk);
        chk("drain_done_ready", 32'(req_ready), 1);
        chk("drain_done_busy", 32'(busy), 0);

        // Flush coinciding with done: straight to IDLE
        step();
        issue(3'b100, 32'd20, 32'd3, 5'd8);
        step();
        step();
        flush      = 1'b1;
        div_done   = 1'b1;
        div_result = 32'd6;
        step();
        flush      = 1'b0;
        div_done   = 1'b0;
        div_result = 32'hBAD0_0002;
        @(negedge clk);
        chk("flush_done_idle", 32'(busy), 0);
        chk("flush_done_ready", 32'(req_ready), 1);
        chk("flush_done_novalid", 32'(resp_valid), 0);

        // Response back-pressure for three cycles
        step();
        resp_ready = 1'b0;
        sb.push_back('{res: 32'h0000_1234, rd: 5'd9, err: 1'b0});
        issue(3'b011, 32'd2, 32'd3, 5'd9);
        mult_done   = 1'b1;
        mult_result = 32'h0000_1234;
        step();
        mult_done   = 1'b0;
        mult_result = 32'hBAD0_0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 1);
            chk("bp_result", resp_result, 32'h0000_1234);
            chk("bp_rd", 32'(resp_rd), 32'd9);
            chk("bp_ready_low", 32'(req_ready), 0);
            step();
        end
        resp_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_release_idle", 32'(busy), 0);

        // Watchdog: mult_done withheld
        step();
        sb.push_back('{res: 32'd0, rd: 5'd10, err: 1'b1});
        issue(3'b001, 32'd5, 32'd5, 5'd10);
        early = 0;
        for (int k = 1; k <= MW; k++) begin
            step();
            @(negedge clk);
            if (resp_valid) early++;
        end
        chk("wd_no_early", 32'(early), 0);
        step();
        @(negedge clk);
        chk("wd_valid", 32'(resp_valid), 1);
        chk("wd_err", 32'(resp_err), 1);
        step();

        // Reset in the middle of DIV_WAIT
        issue(3'b100, 32'd20, 32'd3, 5'd11);
        step();
        rst = 1'b1;
        #1;
        chk("mrst_ready", 32'(req_ready), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_starts", 32'({mult_start, div_start}), 0);
        chk("mrst_valid_err", 32'({resp_valid, resp_err}), 0);
        chk("mrst_op_a", unit_op_a, 0);
        chk("mrst_op_b", unit_op_b, 0);
        chk("mrst_f3_rd", 32'({unit_funct3, resp_rd}), 0);
        chk("mrst_result", resp_result, 0);
        step();
        rst = 1'b0;
        step();
        sb.push_back('{res: 32'd9, rd: 5'd12, err: 1'b0});
        issue(3'b000, 32'd3, 32'd3, 5'd12);
        div_done   = 1'b1;
        div_result = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("post_rst_start", 32'(mult_start), 1);
        step();
        div_done   = 1'b0;
        div_result = 32'hBAD0_0002;
        @(negedge clk);
        chk("stale_div_ignored", 32'(resp_valid), 0);
        step();
        mult_done   = 1'b1;
        mult_result = 32'd9;
        step();
        mult_done   = 1'b0;
        mult_result = 32'hBAD0_0001;
        @(negedge clk);
        chk("post_rst_latency", 32'(resp_valid), 1);
        step();
        step();
        chk("sb_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
